// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, error codes and status bit positions shared by the MMIO register bank.
package mmio_pkg;

  localparam logic [5:0] OFF_WIDTH_LO  = 6'h00;
  localparam logic [5:0] OFF_WIDTH_HI  = 6'h01;
  localparam logic [5:0] OFF_HEIGHT_LO = 6'h02;
  localparam logic [5:0] OFF_HEIGHT_HI = 6'h03;
  localparam logic [5:0] OFF_SCALE_LO  = 6'h04;
  localparam logic [5:0] OFF_SCALE_HI  = 6'h05;
  localparam logic [5:0] OFF_MODE      = 6'h06;
  localparam logic [5:0] OFF_STATUS    = 6'h07;
  localparam logic [5:0] OFF_CTRL      = 6'h08;
  localparam logic [5:0] OFF_ERR_CODE  = 6'h09;
  localparam logic [5:0] OFF_IMG_LO    = 6'h0E;
  localparam logic [5:0] OFF_IMG_HI    = 6'h0F;

  localparam logic [7:0] ERR_NONE       = 8'h00;
  localparam logic [7:0] ERR_RANGE      = 8'h01;
  localparam logic [7:0] ERR_BUSY       = 8'h02;
  localparam logic [7:0] ERR_START_BUSY = 8'h03;

  localparam int ST_BUSY_BIT    = 0;
  localparam int ST_DONE_BIT    = 1;
  localparam int ST_ERR_BIT     = 2;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  function automatic logic is_cfg(input logic [5:0] off);
    return (off <= OFF_MODE) || (off == OFF_IMG_LO) || (off == OFF_IMG_HI);
  endfunction

  function automatic logic is_field_lo(input logic [5:0] off);
    return (off == OFF_WIDTH_LO) || (off == OFF_HEIGHT_LO) ||
           (off == OFF_SCALE_LO) || (off == OFF_IMG_LO);
  endfunction

  function automatic logic is_field_hi(input logic [5:0] off);
    return (off == OFF_WIDTH_HI) || (off == OFF_HEIGHT_HI) ||
           (off == OFF_SCALE_HI) || (off == OFF_IMG_HI);
  endfunction

  // Shadow slot: width=0, height=1, scale=2, image_in_base=3
  function automatic logic [1:0] field_idx(input logic [5:0] off);
    return off[3] ? 2'd3 : off[2:1];
  endfunction

endpackage

// File: rtl/mmio_w1c_bit.sv
// mmio_w1c_bit: sticky status bit, set by an event, cleared by write-1; set has priority.
module mmio_w1c_bit (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q;

  // Sticky bit with set-over-clear priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (set_i) begin
      q_q <= 1'b1;
    end else if (clr_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mmio_regbank.sv
// mmio_regbank: byte-wide MMIO register window configuring an image engine.
// Define MMIO_SHADOW_EN to make 16-bit fields commit atomically on their high-byte write.
module mmio_regbank
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
  parameter int unsigned       NUM_REGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  input  logic              busy_in,
  input  logic              done_in,
  output logic [15:0]       width,
  output logic [15:0]       height,
  output logic [15:0]       scale_q8_8,
  output logic [15:0]       image_in_base,
  output logic [7:0]        mode_reg,
  output logic [7:0]        status_reg,
  output logic              start_pulse
);

  localparam int unsigned       OFF_W      = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [7:0]        bank_q [NUM_REGS];
  logic [7:0]        err_code_q, err_code_d;
  logic              wr_ack_q, wr_err_q, wr_err_d;
  logic              rd_valid_q;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              pending_q, start_d, start_pulse_q;
  logic              st_done_q, st_err_q;
  logic [7:0]        status_s;
  logic [ADDR_W-1:0] wr_rel_s, rd_rel_s;
  logic              wr_in_win_s, rd_in_win_s;
  logic [5:0]        wr_off_s, rd_off_s;
  logic [OFF_W-1:0]  wr_idx_s, rd_idx_s;
  logic              bank_we_s, clr_all_s, done_clr_s, err_clr_s;
  logic [1:0]        st_clr_s;
`ifdef MMIO_SHADOW_EN
  logic [7:0]        shadow_q [4];
  logic              shadow_we_s, commit_s;
`endif

  assign wr_rel_s    = wr_addr - BASE_ADDR;
  assign wr_in_win_s = (wr_addr >= BASE_ADDR) && (wr_rel_s < NUM_REGS_A);
  assign wr_off_s    = wr_rel_s[5:0];
  assign wr_idx_s    = wr_off_s[OFF_W-1:0];
  assign rd_rel_s    = rd_addr - BASE_ADDR;
  assign rd_in_win_s = (rd_addr >= BASE_ADDR) && (rd_rel_s < NUM_REGS_A);
  assign rd_off_s    = rd_rel_s[5:0];
  assign rd_idx_s    = rd_off_s[OFF_W-1:0];

  // Busy is a live level, so it bypasses reset and registering
  always_comb begin
    status_s              = 8'h00;
    status_s[ST_BUSY_BIT] = busy_in;
    status_s[ST_DONE_BIT] = st_done_q;
    status_s[ST_ERR_BIT]  = st_err_q;
  end

  // Write decode: rejection checks first, then per-offset side effects
  always_comb begin
    wr_err_d   = 1'b0;
    err_code_d = err_code_q;
    start_d    = 1'b0;
    clr_all_s  = 1'b0;
    st_clr_s   = 2'b00;
    bank_we_s  = 1'b0;
`ifdef MMIO_SHADOW_EN
    shadow_we_s = 1'b0;
    commit_s    = 1'b0;
`endif
    if (wr_en) begin
      if (!wr_in_win_s) begin
        wr_err_d   = 1'b1;
        err_code_d = ERR_RANGE;
      end else if (is_cfg(wr_off_s) && busy_in) begin
        wr_err_d   = 1'b1;
        err_code_d = ERR_BUSY;
      end else if ((wr_off_s == OFF_CTRL) && wr_data[CTRL_START_BIT] && busy_in) begin
        wr_err_d   = 1'b1;
        err_code_d = ERR_START_BUSY;
      end else begin
        case (wr_off_s)
          OFF_STATUS: st_clr_s = {wr_data[ST_ERR_BIT], wr_data[ST_DONE_BIT]};
          OFF_CTRL: begin
            start_d = wr_data[CTRL_START_BIT];
            if (wr_data[CTRL_CLEAR_BIT]) begin
              clr_all_s  = 1'b1;
              err_code_d = ERR_NONE;
            end else begin
              clr_all_s  = 1'b0;
            end
          end
          OFF_ERR_CODE: bank_we_s = 1'b0;
          default: begin
`ifdef MMIO_SHADOW_EN
            if (is_field_lo(wr_off_s)) begin
              shadow_we_s = 1'b1;
            end else if (is_field_hi(wr_off_s)) begin
              bank_we_s = 1'b1;
              commit_s  = 1'b1;
            end else begin
              bank_we_s = 1'b1;
            end
`else
            bank_we_s = 1'b1;
`endif
          end
        endcase
      end
    end else begin
      wr_err_d = 1'b0;
    end
  end

  assign done_clr_s = st_clr_s[0] | clr_all_s;
  assign err_clr_s  = st_clr_s[1] | clr_all_s;

  // Read mux samples current state, so a same-cycle write is not yet visible
  always_comb begin
    rd_data_d = 8'h00;
    if (rd_en && rd_in_win_s) begin
      case (rd_off_s)
        OFF_STATUS:   rd_data_d = status_s;
        OFF_CTRL:     rd_data_d = 8'h00;
        OFF_ERR_CODE: rd_data_d = err_code_q;
        default: begin
`ifdef MMIO_SHADOW_EN
          if (is_field_lo(rd_off_s)) begin
            rd_data_d = shadow_q[field_idx(rd_off_s)];
          end else begin
            rd_data_d = bank_q[rd_idx_s];
          end
`else
          rd_data_d = bank_q[rd_idx_s];
`endif
        end
      endcase
    end else begin
      rd_data_d = 8'h00;
    end
  end

  // Register bank, bus responses, error code and the two-stage start pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= 8'h00;
      err_code_q    <= 8'h00;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'h00;
      pending_q     <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      if (bank_we_s) bank_q[wr_idx_s] <= wr_data;
`ifdef MMIO_SHADOW_EN
      if (commit_s) bank_q[{wr_idx_s[OFF_W-1:1], 1'b0}] <= shadow_q[field_idx(wr_off_s)];
`endif
      err_code_q    <= err_code_d;
      wr_ack_q      <= wr_en;
      wr_err_q      <= wr_err_d;
      rd_valid_q    <= rd_en;
      rd_data_q     <= rd_data_d;
      pending_q     <= start_d;
      start_pulse_q <= pending_q;
    end
  end

`ifdef MMIO_SHADOW_EN
  // Low-byte staging for atomic 16-bit commits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'h00;
    end else if (shadow_we_s) begin
      shadow_q[field_idx(wr_off_s)] <= wr_data;
    end else begin
      shadow_q <= shadow_q;
    end
  end
`endif

  mmio_w1c_bit u_done (
    .clk   (clk),
    .rst   (rst),
    .set_i (done_in),
    .clr_i (done_clr_s),
    .q_o   (st_done_q)
  );

  mmio_w1c_bit u_err (
    .clk   (clk),
    .rst   (rst),
    .set_i (wr_err_d),
    .clr_i (err_clr_s),
    .q_o   (st_err_q)
  );

  assign wr_ack        = wr_ack_q;
  assign wr_err        = wr_err_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign start_pulse   = start_pulse_q;
  assign status_reg    = status_s;
  assign width         = {bank_q[1], bank_q[0]};
  assign height        = {bank_q[3], bank_q[2]};
  assign scale_q8_8    = {bank_q[5], bank_q[4]};
  assign mode_reg      = bank_q[6];
  assign image_in_base = {bank_q[15], bank_q[14]};

endmodule

// File: tb/tb_mmio_regbank.sv
// tb_mmio_regbank: directed scoreboard bench for mmio_regbank (default window F0..FF).
module tb_mmio_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, busy_in = 1'b0, done_in = 1'b0;
  logic [7:0]  wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00;
  logic        wr_ack, wr_err, rd_valid, start_pulse;
  logic [7:0]  rd_data, mode_reg, status_reg;
  logic [15:0] width, height, scale_q8_8, image_in_base;

  int          pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic [7:0]  rd_q [$];
  logic        wr_q [$];
  logic [15:0] width_after_lo;

  always #5 clk = ~clk;

  mmio_regbank dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy_in(busy_in), .done_in(done_in),
    .width(width), .height(height), .scale_q8_8(scale_q8_8), .image_in_base(image_in_base),
    .mode_reg(mode_reg), .status_reg(status_reg),
    .start_pulse(start_pulse)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, queue expectations, compare responses 1ns after the edge
  task automatic step(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                      input logic re, input logic [7:0] ra, input logic [7:0] rexp,
                      input logic werr);
    logic [7:0] exp_d;
    logic       exp_e;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re && !rst) rd_q.push_back(rexp);
    if (we && !rst) wr_q.push_back(werr);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("rd_valid", rd_valid, 16'(rd_q.size() != 0));
    if (rd_q.size() != 0) begin
      exp_d = rd_q.pop_front();
      check("rd_data", rd_data, exp_d);
    end
    check("wr_ack", wr_ack, 16'(wr_q.size() != 0));
    if (wr_q.size() != 0) begin
      exp_e = wr_q.pop_front();
      check("wr_err", wr_err, exp_e);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic e);
    step(1'b1, a, d, 1'b0, 8'h00, 8'h00, e);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    step(1'b0, 8'h00, 8'h00, 1'b1, a, exp, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
`ifdef MMIO_SHADOW_EN
    width_after_lo = 16'h0000;
`else
    width_after_lo = 16'h0034;
`endif
    // Reset, with busy visible through it
    rst = 1'b1; busy_in = 1'b1;
    idle();
    check("status_busy_in_reset", status_reg, 16'h0001);
    busy_in = 1'b0;
    idle();
    check("rst_width", width, 16'h0000);
    check("rst_image", image_in_base, 16'h0000);
    check("rst_status", status_reg, 16'h0000);
    check("rst_start", start_pulse, 16'h0000);
    rst = 1'b0;

    // 16-bit field write
    wr(8'hF0, 8'h34, 1'b0);
    check("width_after_lo", width, width_after_lo);
    wr(8'hF1, 8'h12, 1'b0);
    check("width_after_hi", width, 16'h1234);
    rd(8'hF0, 8'h34);

    // Config write while busy
    busy_in = 1'b1;
    wr(8'hF2, 8'h55, 1'b1);
    check("height_unchanged", height, 16'h0000);
    rd(8'hF9, 8'h02);
    rd(8'hF7, 8'h05);
    check("status_busy_err", status_reg, 16'h0005);

    // Start while busy is rejected
    wr(8'hF8, 8'h01, 1'b1);
    idle();
    check("no_start_busy", start_pulse, 16'h0000);
    rd(8'hF9, 8'h03);

    // Ctrl clear
    busy_in = 1'b0;
    wr(8'hF8, 8'h02, 1'b0);
    check("status_cleared", status_reg, 16'h0000);
    rd(8'hF9, 8'h00);

    // Start pulse timing
    wr(8'hF8, 8'h01, 1'b0);
    check("start_t1", start_pulse, 16'h0000);
    idle();
    check("start_t2", start_pulse, 16'h0001);
    idle();
    check("start_t3", start_pulse, 16'h0000);
    rd(8'hF8, 8'h00);

    // done set beats same-cycle W1C
    done_in = 1'b1;
    wr(8'hF7, 8'h02, 1'b0);
    done_in = 1'b0;
    check("done_set_wins", status_reg, 16'h0002);
    wr(8'hF7, 8'h02, 1'b0);
    check("done_cleared", status_reg, 16'h0000);

    // Out-of-window
    wr(8'hE0, 8'hAA, 1'b1);
    rd(8'hF9, 8'h01);
    check("status_err_range", status_reg, 16'h0004);
    rd(8'hE0, 8'h00);
    wr(8'hF8, 8'h02, 1'b0);
    wr(8'hEF, 8'h11, 1'b1);
    rd(8'hF9, 8'h01);
    wr(8'hF7, 8'h04, 1'b0);
    check("err_w1c", status_reg, 16'h0000);

    // Read-during-write on mode
    wr(8'hF6, 8'h3C, 1'b0);
    step(1'b1, 8'hF6, 8'h07, 1'b1, 8'hF6, 8'h3C, 1'b0);
    rd(8'hF6, 8'h07);
    check("mode_reg", mode_reg, 16'h0007);

    // Top-of-window field, scratch, status bit0 write ignored
    wr(8'hFE, 8'hCD, 1'b0);
    wr(8'hFF, 8'hAB, 1'b0);
    check("image_in_base", image_in_base, 16'hABCD);
    rd(8'hFE, 8'hCD);
    wr(8'hFA, 8'h5A, 1'b0);
    rd(8'hFA, 8'h5A);
    wr(8'hF7, 8'h01, 1'b0);
    check("status_bit0_ro", status_reg, 16'h0000);

    // Reset cancels a pending start and read
    wr(8'hF8, 8'h01, 1'b0);
    rst = 1'b1;
    rd(8'hF6, 8'h00);
    check("rst_cancels_start", start_pulse, 16'h0000);
    check("rst_mode", mode_reg, 16'h0000);
    check("rst_width2", width, 16'h0000);
    check("rst_image2", image_in_base, 16'h0000);
    rst = 1'b0;
    idle();
    check("no_late_start", start_pulse, 16'h0000);
    rd(8'hF9, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
